nanov_spi_arbiter: RTL

Shares the single SPI memory bus between the nanoV CPU and one alternate master, such as a boot loader, debug bridge or DMA engine. The CPU owns the bus by default. The alternate master is granted the bus only at a CPU chip-select boundary; the CPU is frozen through a stall output while it is displaced. The block sits between the CPU's SPI pins and the top-level SPI pads.

---
 rtl/nanov_arb_pkg.sv | 13 +
 rtl/nanov_arb_turn_ctr.sv | 20 ++
 rtl/nanov_spi_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/nanov_arb_pkg.sv
// nanov_arb_pkg: shared states, defaults and idle-bus constant for the nanoV SPI arbiter
package nanov_arb_pkg;
  typedef enum logic [1:0] {ST_CPU, ST_TO_ALT, ST_ALT, ST_TO_CPU} arb_state_t;
  typedef struct packed {
    logic sel;
    logic clk_en;
    logic dout;
  } spi_bus_t;
  localparam int DEF_TURN_CYCLES = 4;
  localparam int DEF_CPU_MIN_CYCLES = 64;
  localparam int DEF_MAX_ALT_CYCLES = 1024;
  localparam spi_bus_t bus_idle = '{sel: 1'b1, clk_en: 1'b0, dout: 1'b0};
endpackage

// File: rtl/nanov_arb_turn_ctr.sv
// nanov_arb_turn_ctr: turnaround counter, o_done in the last of N cycles after a clear
module nanov_arb_turn_ctr
  import nanov_arb_pkg::*;
#(
  parameter int N = DEF_TURN_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_done
);
  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] last = W'(N - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (!o_done) r_cnt <= r_cnt + 1'b1;
  assign o_done = r_cnt >= last;
endmodule

// File: rtl/nanov_spi_arbiter.sv
// nanov_spi_arbiter: shares the SPI memory bus between the nanoV CPU and an alternate master.
// Optional alt-tenure timeout enabled by defining NANOV_ARB_TIMEOUT_EN.
module nanov_spi_arbiter
  import nanov_arb_pkg::*;
#(
  parameter int TURN_CYCLES    = DEF_TURN_CYCLES,
  parameter int CPU_MIN_CYCLES = DEF_CPU_MIN_CYCLES,
  parameter int MAX_ALT_CYCLES = DEF_MAX_ALT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_spi_select,
  input  logic cpu_spi_out,
  input  logic cpu_spi_clk_enable,
  output logic cpu_stall,
  input  logic alt_req,
  output logic alt_gnt,
  input  logic alt_spi_select,
  input  logic alt_spi_out,
  input  logic alt_spi_clk_enable,
  output logic alt_timeout,
  output logic spi_select,
  output logic spi_out,
  output logic spi_clk_enable,
  input  logic spi_data_in,
  output logic data_in_out
);
  localparam int TW = $clog2(CPU_MIN_CYCLES + 1);
  localparam logic [TW-1:0] ten_max = TW'(CPU_MIN_CYCLES);
  arb_state_t r_state, w_state_nx;
  logic [TW-1:0] r_ten;
  logic r_alt_gnt;
  logic w_ten_done, w_grant, w_turn_done, w_to_hit, w_to_block;
  spi_bus_t w_cpu_bus, w_alt_bus, w_bus;

`ifdef NANOV_ARB_TIMEOUT_EN
  localparam int AW = $clog2(MAX_ALT_CYCLES + 1);
  localparam logic [AW-1:0] alt_last = AW'(MAX_ALT_CYCLES - 1);
  logic [AW-1:0] r_alt_cnt;
  logic r_timeout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_alt_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_alt_cnt <= (r_state == ST_ALT) ? r_alt_cnt + 1'b1 : '0;
      r_timeout <= w_to_hit | (r_timeout & alt_req);
    end
  assign w_to_hit = (r_state == ST_ALT) && (r_alt_cnt >= alt_last);
  assign w_to_block = r_timeout;
  assign alt_timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign w_to_block = 1'b0;
  assign alt_timeout = 1'b0;
`endif

  nanov_arb_turn_ctr #(.N(TURN_CYCLES)) u_turn (
    .clk(clk),
    .rst(rst),
    .i_clr(w_state_nx != r_state),
    .o_done(w_turn_done)
  );

  assign w_ten_done = r_ten >= ten_max;
  assign w_grant = (r_state == ST_CPU) && alt_req && cpu_spi_select && w_ten_done && !w_to_block;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_CPU:    w_state_nx = w_grant ? ST_TO_ALT : ST_CPU;
      ST_TO_ALT: w_state_nx = w_turn_done ? ST_ALT : ST_TO_ALT;
      ST_ALT:    w_state_nx = (w_to_hit || (!alt_req && alt_spi_select)) ? ST_TO_CPU : ST_ALT;
      ST_TO_CPU: w_state_nx = w_turn_done ? ST_CPU : ST_TO_CPU;
      default:   w_state_nx = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= ST_CPU;
      r_ten     <= '0;
      r_alt_gnt <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ten     <= (r_state != ST_CPU) ? '0 : w_ten_done ? r_ten : r_ten + 1'b1;
      r_alt_gnt <= w_state_nx == ST_ALT;
    end

  // Bus is forced idle during reset even though the state already reads CPU.
  assign w_cpu_bus = '{sel: cpu_spi_select, clk_en: cpu_spi_clk_enable, dout: cpu_spi_out};
  assign w_alt_bus = '{sel: alt_spi_select, clk_en: alt_spi_clk_enable, dout: alt_spi_out};
  assign w_bus = rst ? bus_idle : (r_state == ST_CPU) ? w_cpu_bus : (r_state == ST_ALT) ? w_alt_bus : bus_idle;
  assign spi_select = w_bus.sel;
  assign spi_clk_enable = w_bus.clk_en;
  assign spi_out = w_bus.dout;
  assign data_in_out = spi_data_in;
  assign cpu_stall = (r_state != ST_CPU) || w_grant;
  assign alt_gnt = r_alt_gnt;
endmodule
